bist_ctrl: RTL

BIST_CTRL -- requirements
Module: bist_ctrl

---
 rtl/bist_ctrl_if.sv | 31 +++
 rtl/bist_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/bist_ctrl_if.sv
// Signal bundle between the BIST controller and its environment (CUT pair + host).
interface bist_ctrl_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = PAT_W + 1
);
  logic             start;
  logic             abort;
  logic             cut_f;
  logic             gold_f;
  logic [PAT_W-1:0] pattern;
  logic             fault_inject;
  logic             busy;
  logic             done;
  logic             pass0_ok;
  logic             detected;
  logic [CNT_W-1:0] err_cnt;
  logic [PAT_W-1:0] first_fail;
  logic [15:0]      signature;

  modport slave (
    input  start, abort, cut_f, gold_f,
    output pattern, fault_inject, busy, done, pass0_ok, detected,
           err_cnt, first_fail, signature
  );

  modport master (
    output start, abort, cut_f, gold_f,
    input  pattern, fault_inject, busy, done, pass0_ok, detected,
           err_cnt, first_fail, signature
  );
endinterface

// File: rtl/bist_ctrl.sv
// Two-pass exhaustive BIST controller: fault-free pass, then fault-injected pass.
// Optional response signature MISR enabled by defining BIST_MISR_EN.
module bist_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = PAT_W + 1
) (
  input logic       clk,
  input logic       rst,
  bist_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN0, RUN1, DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic             fi_q, fi_d;
  logic             pass0_q, pass0_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [PAT_W-1:0] ff_q, ff_d;
  logic             mismatch;
  logic             last_pat;

  assign mismatch = bus.cut_f ^ bus.gold_f;
  assign last_pat = (pattern_q == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // abort outranks the end-of-pass transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN0;
      RUN0: begin
        if (bus.abort)     state_d = IDLE;
        else if (last_pat) state_d = RUN1;
      end
      RUN1: begin
        if (bus.abort)     state_d = IDLE;
        else if (last_pat) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN0) || (state_q == RUN1);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    pattern_d = pattern_q;
    fi_d      = fi_q;
    pass0_d   = pass0_q;
    det_d     = det_q;
    err_d     = err_q;
    ff_d      = ff_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          pattern_d = '0;
          fi_d      = 1'b0;
          pass0_d   = 1'b1;
          det_d     = 1'b0;
          err_d     = '0;
          ff_d      = '0;
        end
      end
      RUN0: begin
        if (bus.abort) begin
          pattern_d = '0;
          fi_d      = 1'b0;
        end else begin
          pattern_d = pattern_q + PAT_W'(1);
          if (mismatch) pass0_d = 1'b0;
          if (last_pat) fi_d = 1'b1;
        end
      end
      RUN1: begin
        if (bus.abort) begin
          pattern_d = '0;
          fi_d      = 1'b0;
        end else begin
          pattern_d = pattern_q + PAT_W'(1);
          if (mismatch) begin
            err_d = (err_q == '1) ? err_q : err_q + CNT_W'(1);
            det_d = 1'b1;
            if (!det_q) ff_d = pattern_q;
          end
          if (last_pat) fi_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= '0;
      fi_q      <= 1'b0;
      pass0_q   <= 1'b0;
      det_q     <= 1'b0;
      err_q     <= '0;
      ff_q      <= '0;
    end else begin
      pattern_q <= pattern_d;
      fi_q      <= fi_d;
      pass0_q   <= pass0_d;
      det_q     <= det_d;
      err_q     <= err_d;
      ff_q      <= ff_d;
    end
  end

  assign bus.pattern      = pattern_q;
  assign bus.fault_inject = fi_q;
  assign bus.pass0_ok     = pass0_q;
  assign bus.detected     = det_q;
  assign bus.err_cnt      = err_q;
  assign bus.first_fail   = ff_q;

`ifdef BIST_MISR_EN
  logic [15:0] sig_q, sig_d;
  logic        sig_fb;

  // x^16+x^12+x^5+1, MSB-first shift of cut_f
  always_comb begin
    sig_d  = sig_q;
    sig_fb = sig_q[15] ^ bus.cut_f;
    unique case (state_q)
      IDLE, DONE: if (bus.start) sig_d = '1;
      default:    sig_d = {sig_q[14:0], 1'b0} ^ (sig_fb ? 16'h1021 : 16'h0000);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign bus.signature = sig_q;
`else
  assign bus.signature = '0;
`endif

endmodule
